// File: rtl/pipelined_ripple_adder.sv
// ---------------------------------------------------------------------------
// pipelined_ripple_adder
//
// Purpose:
//   Pipelined WIDTH-bit adder. The add is split into NSEG = WIDTH/SEG ripple
//   segments with one segment per stage. The carry is registered between
//   stages, so the critical path is one SEG-bit ripple at any WIDTH.
//   Valid/ready stream interface with one add per cycle throughput.
//   Latency is NSEG cycles from acceptance to out_valid.
//
// Parameters:
//   WIDTH  operand / sum width in bits
//   SEG    bits summed per stage; WIDTH must be a multiple of SEG
//
// Ports:
//   clk        in   1      rising-edge clock
//   reset_n    in   1      asynchronous, active-low reset
//   in_valid   in   1      a, b and cin are valid this cycle
//   in_ready   out  1      stage 0 can accept this cycle
//   a          in   WIDTH  operand A (unsigned or two's complement)
//   b          in   WIDTH  operand B
//   cin        in   1      carry into bit 0
//   out_valid  out  1      s_out / c_out are valid
//   out_ready  in   1      downstream accepts this cycle
//   s_out      out  WIDTH  (a + b + cin) mod 2^WIDTH
//   c_out      out  1      carry out of bit WIDTH-1
//   ovf        out  1      signed overflow (only with PIPE_ADDER_OVF_EN)
//
// Optional feature macro:
//   PIPE_ADDER_OVF_EN  adds the ovf port and a sign-bit pipeline that keeps
//                      ovf aligned with s_out.
// ---------------------------------------------------------------------------
module pipelined_ripple_adder #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s_out,
    output logic             c_out
`ifdef PIPE_ADDER_OVF_EN
    , output logic           ovf
`endif
);

    localparam int NSEG = WIDTH / SEG;

    if ((SEG < 1) || (WIDTH % SEG != 0)) begin : g_bad_params
        $error("pipelined_ripple_adder: WIDTH must be a non-zero multiple of SEG");
    end

    // The whole pipe moves together: it advances whenever the output slot
    // is empty or being drained. Bubbles shift along with real data.
    logic advance;

    assign advance  = ~out_valid | out_ready;
    assign in_ready = advance;

    // Each stage adds one SEG-bit slice. The register after stage k holds
    // the finished sum bits [(k+1)*SEG-1:0], the carry into the next slice
    // and (if any remain) the operand bits that are still to be summed.
    for (genvar k = 0; k < NSEG; k++) begin : g_stage
        logic [SEG-1:0]         seg_a;
        logic [SEG-1:0]         seg_b;
        logic                   carry_in;
        logic                   valid_in;
        logic [SEG:0]           seg_sum;
        logic [(k+1)*SEG-1:0]   sum_next;
        logic [(k+1)*SEG-1:0]   sum_q;
        logic                   carry_q;
        logic                   v_q;
`ifdef PIPE_ADDER_OVF_EN
        logic                   sign_a_in;
        logic                   sign_b_in;
        logic                   sign_a_q;
        logic                   sign_b_q;
`endif

        if (k == 0) begin : g_head
            assign seg_a    = a[SEG-1:0];
            assign seg_b    = b[SEG-1:0];
            assign carry_in = cin;
            assign valid_in = in_valid;
            assign sum_next = seg_sum[SEG-1:0];
`ifdef PIPE_ADDER_OVF_EN
            assign sign_a_in = a[WIDTH-1];
            assign sign_b_in = b[WIDTH-1];
`endif
        end else begin : g_body
            // The previous stage kept the unsummed operand bits right-aligned,
            // so this slice is always its lowest SEG bits.
            assign seg_a    = g_stage[k-1].g_opnd.opa_q[SEG-1:0];
            assign seg_b    = g_stage[k-1].g_opnd.opb_q[SEG-1:0];
            assign carry_in = g_stage[k-1].carry_q;
            assign valid_in = g_stage[k-1].v_q;
            assign sum_next = {seg_sum[SEG-1:0], g_stage[k-1].sum_q};
`ifdef PIPE_ADDER_OVF_EN
            assign sign_a_in = g_stage[k-1].sign_a_q;
            assign sign_b_in = g_stage[k-1].sign_b_q;
`endif
        end

        assign seg_sum = {1'b0, seg_a} + {1'b0, seg_b} + {{SEG{1'b0}}, carry_in};

        // Stage register: valid bit, partial sum and carry. Holds on stall.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                v_q     <= 1'b0;
                sum_q   <= '0;
                carry_q <= 1'b0;
            end else if (advance) begin
                v_q     <= valid_in;
                sum_q   <= sum_next;
                carry_q <= seg_sum[SEG];
            end
        end

`ifdef PIPE_ADDER_OVF_EN
        // Operand sign bits travel with the data so ovf lines up with s_out.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                sign_a_q <= 1'b0;
                sign_b_q <= 1'b0;
            end else if (advance) begin
                sign_a_q <= sign_a_in;
                sign_b_q <= sign_b_in;
            end
        end
`endif

        // Operand bits not yet summed; the last stage has none left.
        if (k < NSEG - 1) begin : g_opnd
            localparam int REM = WIDTH - (k + 1) * SEG;

            logic [REM-1:0] opa_next;
            logic [REM-1:0] opb_next;
            logic [REM-1:0] opa_q;
            logic [REM-1:0] opb_q;

            if (k == 0) begin : g_src_port
                assign opa_next = a[WIDTH-1:SEG];
                assign opb_next = b[WIDTH-1:SEG];
            end else begin : g_src_prev
                assign opa_next = g_stage[k-1].g_opnd.opa_q[SEG +: REM];
                assign opb_next = g_stage[k-1].g_opnd.opb_q[SEG +: REM];
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    opa_q <= '0;
                    opb_q <= '0;
                end else if (advance) begin
                    opa_q <= opa_next;
                    opb_q <= opb_next;
                end
            end
        end
    end

    assign out_valid = g_stage[NSEG-1].v_q;
    assign s_out     = g_stage[NSEG-1].sum_q;
    assign c_out     = g_stage[NSEG-1].carry_q;

`ifdef PIPE_ADDER_OVF_EN
    // Signed overflow: like-signed operands produced a result of the other sign.
    assign ovf = (g_stage[NSEG-1].sign_a_q == g_stage[NSEG-1].sign_b_q) &
                 (s_out[WIDTH-1] != g_stage[NSEG-1].sign_a_q);
`endif

endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// ---------------------------------------------------------------------------
// tb_pipelined_ripple_adder
//
// Purpose:
//   Self-checking bench for pipelined_ripple_adder (WIDTH=16, SEG=4) plus a
//   small single-stage instance (WIDTH=8, SEG=8). Directed vectors carry
//   hand-computed results that are queued on acceptance and compared by an
//   independent output monitor.
// ---------------------------------------------------------------------------
module tb_pipelined_ripple_adder;

    localparam int LAT = 4;

    typedef struct {
        logic [15:0] s;
        logic        c;
        logic        o;
        int          acc_cyc;
        bit          exact;
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] s_out;
    logic        c_out;
    logic        ovf;

    logic        in_valid8;
    logic        in_ready8;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic        cin8;
    logic        out_valid8;
    logic        out_ready8;
    logic [7:0]  s_out8;
    logic        c_out8;
    logic        ovf8;

    exp_t        sb_q[$];
    int          cyc;
    int          check_cnt;
    int          pass_cnt;
    bit          stall_seen;
    logic [15:0] held_s;
    logic        held_c;
    logic        held_o;

    pipelined_ripple_adder #(.WIDTH(16), .SEG(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s_out     (s_out),
        .c_out     (c_out)
`ifdef PIPE_ADDER_OVF_EN
        , .ovf     (ovf)
`endif
    );

    pipelined_ripple_adder #(.WIDTH(8), .SEG(8)) dut_n1 (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .a         (a8),
        .b         (b8),
        .cin       (cin8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .s_out     (s_out8),
        .c_out     (c_out8)
`ifdef PIPE_ADDER_OVF_EN
        , .ovf     (ovf8)
`endif
    );

`ifndef PIPE_ADDER_OVF_EN
    assign ovf  = 1'b0;
    assign ovf8 = 1'b0;
`endif

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Free-running cycle counter used for latency checks
    always @(posedge clk) cyc <= cyc + 1;

    // Global time limit so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        check_cnt++;
        if (actual === expected)
            pass_cnt++;
        else
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    // Presents one operation (from posedge+2) and holds it until accepted,
    // then queues the hand-computed result. Returns at posedge+2.
    task automatic applyStimulus(input logic [15:0] a_v, input logic [15:0] b_v,
                                 input logic cin_v, input logic [15:0] s_exp,
                                 input logic c_exp, input logic o_exp,
                                 input bit exact);
        bit   accepted;
        logic rdy;
        int   c_before;
        exp_t e;
        accepted = 1'b0;
        in_valid = 1'b1;
        a        = a_v;
        b        = b_v;
        cin      = cin_v;
        for (int t = 0; t < 50 && !accepted; t++) begin
            @(negedge clk);
            rdy      = in_ready;
            c_before = cyc;
            @(posedge clk);
            if (rdy) begin
                e.s       = s_exp;
                e.c       = c_exp;
                e.o       = o_exp;
                e.acc_cyc = c_before;
                e.exact   = exact;
                sb_q.push_back(e);
                accepted  = 1'b1;
            end
        end
        #2;
        in_valid = 1'b0;
        if (!accepted) begin
            check_cnt++;
            $display("[TB] FAIL accept_timeout: got in_ready=0 for 50 cycles, expected acceptance");
        end
    endtask

    // Output monitor: pops the scoreboard on every transfer and checks that a
    // stalled output stays stable and blocks the input side.
    always @(negedge clk) begin
        exp_t e;
        if (!reset_n) begin
            stall_seen = 1'b0;
        end else begin
            if (stall_seen) begin
                checkOutput("stall_s_out", 32'(s_out), 32'(held_s));
                checkOutput("stall_c_out", 32'(c_out), 32'(held_c));
`ifdef PIPE_ADDER_OVF_EN
                checkOutput("stall_ovf", 32'(ovf), 32'(held_o));
`endif
            end
            if (out_valid && !out_ready) begin
                checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
                stall_seen = 1'b1;
                held_s     = s_out;
                held_c     = c_out;
                held_o     = ovf;
            end else begin
                stall_seen = 1'b0;
            end
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check_cnt++;
                    $display("[TB] FAIL unexpected_output: got s_out=0x%0h with nothing queued, expected no output", s_out);
                end else begin
                    e = sb_q.pop_front();
                    checkOutput("s_out", 32'(s_out), 32'(e.s));
                    checkOutput("c_out", 32'(c_out), 32'(e.c));
`ifdef PIPE_ADDER_OVF_EN
                    checkOutput("ovf", 32'(ovf), 32'(e.o));
`endif
                    if (e.exact)
                        checkOutput("latency", 32'(cyc - e.acc_cyc), 32'(LAT));
                end
            end
        end
    end

    // Waits (bounded) for every queued result to come out
    task automatic drainQueue(input string name);
        for (int t = 0; t < 60 && sb_q.size() != 0; t++) @(negedge clk);
        checkOutput(name, 32'(sb_q.size()), 32'd0);
        @(posedge clk);
        #2;
    endtask

    // Main stimulus sequence
    initial begin
        cyc        = 0;
        check_cnt  = 0;
        pass_cnt   = 0;
        stall_seen = 1'b0;
        reset_n    = 1'b0;
        in_valid   = 1'b0;
        a          = '0;
        b          = '0;
        cin        = 1'b0;
        out_ready  = 1'b1;
        in_valid8  = 1'b0;
        a8         = '0;
        b8         = '0;
        cin8       = 1'b0;
        out_ready8 = 1'b1;

        // Reset held for 3 cycles
        repeat (3) @(posedge clk);
        #2;
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_s_out", 32'(s_out), 32'h0000);
        checkOutput("rst_c_out", 32'(c_out), 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        reset_n = 1'b1;
        @(posedge clk);
        #2;

        // Full carry ripple through every segment
        applyStimulus(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        drainQueue("drain_ripple");

        // Back-to-back stream, results on consecutive cycles
        applyStimulus(16'h1234, 16'h1111, 1'b1, 16'h2346, 1'b0, 1'b0, 1'b1);
        applyStimulus(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);
        applyStimulus(16'h00FF, 16'h0F01, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b1);
        applyStimulus(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b1);
        drainQueue("drain_stream");

        // Backpressure: output held for several cycles, then released
        out_ready = 1'b0;
        fork
            begin
                applyStimulus(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
                applyStimulus(16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0);
                applyStimulus(16'h0F0F, 16'hF0F0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0);
                applyStimulus(16'h1000, 16'h2000, 1'b0, 16'h3000, 1'b0, 1'b0, 1'b0);
                applyStimulus(16'hABCD, 16'h1234, 1'b0, 16'hBE01, 1'b0, 1'b0, 1'b0);
            end
            begin
                for (int t = 0; t < 40 && !out_valid; t++) @(negedge clk);
                repeat (4) @(negedge clk);
                @(posedge clk);
                #2;
                out_ready = 1'b1;
            end
        join
        drainQueue("drain_backpressure");

        // Reset while three results are in flight
        applyStimulus(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b1);
        applyStimulus(16'h0002, 16'h0002, 1'b0, 16'h0004, 1'b0, 1'b0, 1'b1);
        applyStimulus(16'h0003, 16'h0003, 1'b0, 16'h0006, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #2;
        checkOutput("pre_reset_valid", 32'(out_valid), 32'd1);
        reset_n = 1'b0;
        #1;
        checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midrst_s_out", 32'(s_out), 32'h0000);
        checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
        sb_q.delete();
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b1;
        repeat (8) @(negedge clk);
        checkOutput("post_reset_idle", 32'(out_valid), 32'd0);
        @(posedge clk);
        #2;
        applyStimulus(16'h4321, 16'h1234, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b1);
        drainQueue("drain_recovery");

        // Single-stage instance: registered adder with latency 1
        a8        = 8'h7F;
        b8        = 8'h01;
        cin8      = 1'b0;
        in_valid8 = 1'b1;
        @(negedge clk);
        checkOutput("n1_in_ready", 32'(in_ready8), 32'd1);
        @(posedge clk);
        #2;
        in_valid8 = 1'b0;
        @(negedge clk);
        checkOutput("n1_out_valid", 32'(out_valid8), 32'd1);
        checkOutput("n1_s_out", 32'(s_out8), 32'h80);
        checkOutput("n1_c_out", 32'(c_out8), 32'd0);
`ifdef PIPE_ADDER_OVF_EN
        checkOutput("n1_ovf", 32'(ovf8), 32'd1);
`endif
        @(negedge clk);
        checkOutput("n1_bubble", 32'(out_valid8), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
